// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display (active-low anodes, segments and dp).
// A slot prescaler drives a BLANK/DRIVE state machine, one anode per slot,
// with a dark gap at the start of each slot to suppress ghosting.
// Displayed data is double-buffered and only swaps at the frame wrap.
// Optional build macro: FND_LZB_EN enables leading-zero blanking.
module fnd_scan_controller #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Hex nibble to active-low gfedcba segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  state_t           state_r;
  logic [15:0]      shadow_r;
  logic [3:0]       shadow_dp_r;
  logic [15:0]      active_r;
  logic [3:0]       active_dp_r;
  logic             pending_r;

  logic             slot_end_s;
  logic             wrap_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [3:0]       nibble_s;
  logic             lz_blank_s;
  logic [6:0]       seg_s;
  logic [3:0]       an_s;

  // Slot/frame timing and the data for the digit currently being scanned.
  always_comb begin
    slot_end_s = 1'b0;
    wrap_s     = 1'b0;
    cnt_next_s = '0;
    nibble_s   = 4'h0;
    lz_blank_s = 1'b0;
    if (i_enable) begin
      slot_end_s = (cnt_r == CNT_LAST);
      wrap_s     = slot_end_s && (idx_r == 2'd3);
      if (slot_end_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
    case (idx_r)
      2'd0:    nibble_s = active_r[3:0];
      2'd1:    nibble_s = active_r[7:4];
      2'd2:    nibble_s = active_r[11:8];
      2'd3:    nibble_s = active_r[15:12];
      default: nibble_s = 4'h0;
    endcase
`ifdef FND_LZB_EN
    // A digit is dark when it and every more significant nibble are zero.
    case (idx_r)
      2'd1:    lz_blank_s = (active_r[15:4]  == 12'h000);
      2'd2:    lz_blank_s = (active_r[15:8]  == 8'h00);
      2'd3:    lz_blank_s = (active_r[15:12] == 4'h0);
      default: lz_blank_s = 1'b0;
    endcase
`else
    lz_blank_s = 1'b0;
`endif
    if (lz_blank_s) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = hex_to_seg(nibble_s);
    end
    an_s = ~(4'b0001 << idx_r);
  end

  // Scan state machine, double buffer and registered pin drivers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      state_r      <= ST_BLANK;
      shadow_r     <= 16'h0000;
      shadow_dp_r  <= 4'h0;
      active_r     <= 16'h0000;
      active_dp_r  <= 4'h0;
      pending_r    <= 1'b0;
      o_an         <= 4'b1111;
      o_seg        <= 7'b1111111;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      state_r <= (cnt_next_s < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
      if (!i_enable) begin
        idx_r <= 2'd0;
      end else if (slot_end_s) begin
        idx_r <= idx_r + 2'd1;
      end else begin
        idx_r <= idx_r;
      end

      // A load landing on the wrap bypasses the shadow and leaves nothing pending.
      if (i_load) begin
        shadow_r    <= i_value;
        shadow_dp_r <= i_dp;
      end else begin
        shadow_r    <= shadow_r;
        shadow_dp_r <= shadow_dp_r;
      end
      if (wrap_s && i_load) begin
        active_r    <= i_value;
        active_dp_r <= i_dp;
        pending_r   <= 1'b0;
      end else if (wrap_s && pending_r) begin
        active_r    <= shadow_r;
        active_dp_r <= shadow_dp_r;
        pending_r   <= 1'b0;
      end else if (i_load) begin
        active_r    <= active_r;
        active_dp_r <= active_dp_r;
        pending_r   <= 1'b1;
      end else begin
        active_r    <= active_r;
        active_dp_r <= active_dp_r;
        pending_r   <= pending_r;
      end

      o_frame_done <= wrap_s;
      case (state_r)
        ST_DRIVE: begin
          if (i_enable) begin
            o_an  <= an_s;
            o_seg <= seg_s;
            o_dp  <= ~active_dp_r[idx_r];
          end else begin
            o_an  <= 4'b1111;
            o_seg <= 7'b1111111;
            o_dp  <= 1'b1;
          end
        end
        default: begin
          o_an  <= 4'b1111;
          o_seg <= 7'b1111111;
          o_dp  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Testbench for fnd_scan_controller: directed scenarios followed by random
// enable/load/reset traffic, checked every cycle against a frame-position model.
module tb_fnd_scan_controller;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int BLANK   = 2;
  localparam int TICK    = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * TICK;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_enable;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic        i_load;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_done;

  fnd_scan_controller #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_value(i_value), .i_dp(i_dp), .i_load(i_load),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16];

  // Reference model: position inside the 40-clock frame plus the two buffers.
  int          pos;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_adp, m_sdp;
  bit          m_pending;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_load(input bit wrap);
    if (i_load) begin
      m_shadow = i_value;
      m_sdp    = i_dp;
      if (wrap) begin
        m_active  = i_value;
        m_adp     = i_dp;
        m_pending = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (wrap && m_pending) begin
      m_active  = m_shadow;
      m_adp     = m_sdp;
      m_pending = 1'b0;
    end
  endtask

  // Expected outputs after the coming edge, then advance the model.
  task automatic model_step();
    int slot, c;
    bit wrap, blank;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
    if (!i_reset_n) begin
      pos = 0; m_active = 16'h0; m_shadow = 16'h0; m_adp = 4'h0; m_sdp = 4'h0; m_pending = 1'b0;
    end else if (!i_enable) begin
      pos = 0;
      model_load(1'b0);
    end else begin
      slot = pos / TICK;
      c    = pos % TICK;
      if (c >= BLANK) begin
        e_an  = 4'b1111 & ~(4'(1) << slot);
        blank = 1'b0;
`ifdef FND_LZB_EN
        blank = (slot > 0) && ((m_active >> (4 * slot)) == 16'h0);
`endif
        e_seg = blank ? 7'b1111111 : seg_tab[(m_active >> (4 * slot)) & 16'hF];
        e_dp  = ~m_adp[slot];
      end
      wrap = (pos == FRAME - 1);
      e_fd = wrap;
      model_load(wrap);
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    check("an", 32'(o_an), 32'(e_an));
    check("seg", 32'(o_seg), 32'(e_seg));
    check("dp", 32'(o_dp), 32'(e_dp));
    check("frame_done", 32'(o_frame_done), 32'(e_fd));
  endtask

  // Tick until the model sits at frame position p (bounded).
  task automatic run_to(input int p);
    int guard = 0;
    while (pos != p && guard < 200) begin
      tick();
      guard++;
    end
    check("run_to_bound", 32'(pos), 32'(p));
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    pos = 0; m_active = 16'h0; m_shadow = 16'h0; m_adp = 4'h0; m_sdp = 4'h0; m_pending = 1'b0;

    // 1: reset, then first driven cycle
    i_reset_n = 1'b0; i_enable = 1'b1; i_value = 16'h0; i_dp = 4'h0; i_load = 1'b0;
    repeat (3) tick();
    check("reset_an", 32'(o_an), 32'h0000_000F);
    i_reset_n = 1'b1;
    repeat (3) tick();
    check("first_an", 32'(o_an), 32'b1110);
    check("first_seg", 32'(o_seg), 32'b1000000);

    // 2: free-running scan of value 0
    repeat (2 * FRAME) tick();

    // 3: load during digit1, applied at the next wrap
    run_to(15);
    i_value = 16'h1234; i_dp = 4'b0100; i_load = 1'b1;
    tick();
    i_load = 1'b0; i_value = 16'h0;
    run_to(0);
    run_to(5);
    tick();
    check("d0_after_load", 32'(o_seg), 32'b0011001);
    run_to(25);
    tick();
    check("d2_after_load", 32'(o_seg), 32'b0100100);
    check("d2_dp", 32'(o_dp), 32'd0);

    // 4: load exactly on the wrap edge
    run_to(FRAME - 1);
    i_value = 16'hABCD; i_dp = 4'h0; i_load = 1'b1;
    tick();
    i_load = 1'b0; i_value = 16'h0;
    repeat (3) tick();
    check("wrap_load_an", 32'(o_an), 32'b1110);
    check("wrap_load_seg", 32'(o_seg), 32'b0100001);
    repeat (FRAME) tick();

    // 5: drop enable in digit2 DRIVE, then reset mid-slot
    run_to(25);
    i_enable = 1'b0;
    tick();
    check("disable_dark", 32'(o_an), 32'b1111);
    repeat (4) tick();
    i_enable = 1'b1;
    tick();
    check("reen_blank0", 32'(o_an), 32'b1111);
    tick();
    check("reen_blank1", 32'(o_an), 32'b1111);
    tick();
    check("reen_d0", 32'(o_an), 32'b1110);
    run_to(14);
    i_reset_n = 1'b0;
    tick();
    check("reset_mid_dark", 32'(o_seg), 32'h7F);
    i_reset_n = 1'b1;
    repeat (FRAME + 5) tick();

    // 6: leading zeros
    run_to(FRAME - 1);
    i_value = 16'h0050; i_load = 1'b1;
    tick();
    i_load = 1'b0;
    run_to(35);
    tick();
`ifdef FND_LZB_EN
    check("lz_d3", 32'(o_seg), 32'b1111111);
`else
    check("lz_d3", 32'(o_seg), 32'b1000000);
`endif
    run_to(15);
    tick();
    check("lz_d1", 32'(o_seg), 32'b0010010);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      i_enable  = ($urandom_range(0, 99) < 96);
      i_load    = ($urandom_range(0, 99) < 6);
      i_value   = 16'($urandom);
      i_dp      = 4'($urandom);
      i_reset_n = ($urandom_range(0, 999) >= 4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed scan controller for the Basys3 4-digit 7-segment display (FND).
- Owns its own digit-slot prescaler and a BLANK/DRIVE state machine that cycles one active anode at a time, with inter-digit dead time to suppress ghosting.
- Double-buffers the displayed value so updates apply only at frame boundaries, so the display never tears.
- Sits between the fan-control datapath (speed/mode values) and the board FND pins.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, digit-slot rate. TICK_DIV = CLK_HZ/SCAN_HZ clocks per slot.
- BLANK_CYCLES, 100, clocks at the start of each slot with all anodes off. Must satisfy 0 < BLANK_CYCLES < TICK_DIV.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  active-low reset
- i_enable  in  1  scan enable
- i_value  in  16  four hex nibbles; [3:0] = digit0 (rightmost)
- i_dp  in  4  decimal-point request per digit, active-high
- i_load  in  1  one-cycle pulse: capture i_value/i_dp into the shadow register
- o_an  out  4  anodes, active-low
- o_seg  out  7  segments, active-low, [6:0] = g f e d c b a
- o_dp  out  1  decimal point, active-low
- o_frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
Clocking and reset
- Single clock i_clk; reset is synchronous, active-low on i_reset_n.
- Reset values: o_an=4'b1111, o_seg=7'b1111111, o_dp=1, o_frame_done=0; prescaler=0, digit index=0, shadow=0, active=0, pending=0, state=BLANK.
- Reset asserted mid-operation clears everything at the next edge; display is dark the following cycle.

Prescaler and state machine
- Prescaler cnt counts 0..TICK_DIV-1 and wraps to 0.
- State is BLANK while cnt < BLANK_CYCLES, DRIVE otherwise.
- At cnt == TICK_DIV-1, the digit index advances 0->1->2->3->0.
- BLANK: o_an=1111, o_seg=1111111, o_dp=1.
- DRIVE: o_an has the bit for the current index low. o_seg is the hex decode of active[index]. o_dp = ~active_dp[index].
- All outputs are registered: they reflect cnt/state/index from the previous cycle (one-clock latency).

Enable
- While i_enable=0: cnt and index held at 0, state forced to BLANK, outputs dark.
- Load capture still operates while disabled.
- When re-enabled, scanning starts at digit 0, slot start.

Load handshake
- i_load=1 copies i_value/i_dp into the shadow register at that edge and sets pending.
- Frame wrap is the edge where index goes 3->0. At that edge, if pending=1, shadow is copied to active and pending clears; o_frame_done pulses for one cycle.
- If i_load coincides with the wrap, i_value/i_dp go directly into active and pending ends at 0.
- Back-to-back loads within one frame: last load wins.

Decode, active-low gfedcba
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Optional Feature:
FND_LZB_EN (leading-zero blanking)
- Defined: during DRIVE, digit k (k=3..1) shows o_seg=1111111 when active[k] and all higher nibbles are 0. Anode timing is unchanged, and o_dp still follows i_dp. Digit 0 is never blanked.
- Undefined: all four digits always decode, including leading zeros.

Test Plan:
Bench uses CLK_HZ=1000, SCAN_HZ=100 (TICK_DIV=10), BLANK_CYCLES=2.
1. Hold i_reset_n=0 for 3 clocks, then release -> during reset o_an=1111, o_seg=1111111, o_dp=1, o_frame_done=0; first driven cycle shows o_an=1110 with digit0 '0' = 1000000.
2. i_enable=1, value 0 -> every slot shows o_an=1111 for 2 clocks, then the one-hot-low anode for 8 clocks, in sequence 1110, 1101, 1011, 0111, repeating every 40 clocks.
3. Pulse i_load with i_value=16'h1234, i_dp=4'b0100 during digit1 -> display unchanged until the wrap; o_frame_done pulses once. Next frame: digit0 o_seg=0011001, digit2 o_seg=0100100 with o_dp=0.
4. i_load at the exact wrap edge with 16'hABCD -> digit0 shows 'd' (0100001) in the immediately following slot; pending=0.
5. Drop i_enable mid-DRIVE on digit2 -> next cycle o_an=1111; on re-enable, o_an=1111 for 2 clocks, then 1110. Drop i_reset_n mid-slot -> outputs dark next cycle and active value cleared.
6. FND_LZB_EN defined, load 16'h0050 -> digits 3 and 2 show 1111111, digit1 '5' (0010010), digit0 '0' (1000000). Without the macro, digits 3 and 2 show 1000000.
